// File: rtl/rv32i_pkg.sv
// Shared constants, FSM state type and size helpers for the RV32I data-memory controller.
package rv32i_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ACC_RD = 2'b01;
  localparam logic [1:0] ACC_WR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    CAP,
    RSP
  } dmem_state_t;

  // Byte-lane mask of an access anchored at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_ld_align.sv
// Load-data alignment: shifts {word1,word0} down by the byte offset, truncates to the
// access size and zero- or sign-extends to 32 bits.
module rv32i_ld_align
  import rv32i_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [1:0]  boff,
  input  logic [1:0]  sz,
  input  logic        s_us,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = dword[{boff, 3'b000} +: 32];

  always_comb begin
    case (sz)
      SZ_B:    data = {{24{~s_us & shifted[7]}},  shifted[7:0]};
      SZ_H:    data = {{16{~s_us & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// Single-request data-memory controller driving a 1-cycle-latency word SRAM.
// Define RV32I_DMEM_MISALIGN_EN to support misaligned and word-crossing accesses.
module rv32i_dmem_ctrl
  import rv32i_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_acc_type,
  input  logic [31:0]   req_adr,
  input  logic [1:0]    req_sz,
  input  logic          req_s_us,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_adr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  dmem_state_t state, state_nxt;

  logic          is_wr_q;
  logic [1:0]    sz_q;
  logic [1:0]    boff_q;
  logic          s_us_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] a_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic          req_legal;
  logic          aligned;
  logic [3:0]    mask;
  logic [63:0]   ld_dword;
  logic [31:0]   ld_data;
  logic          unused_adr_hi;

  // Byte-address bits above the SRAM window are ignored.
  assign unused_adr_hi = ^req_adr[31:AW+2];

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign mask      = size_mask(sz_q);

`ifdef RV32I_DMEM_MISALIGN_EN
  logic [31:0] word0_q;
  logic        crossing;
  logic [2:0]  rshift;

  assign aligned  = 1'b1;
  assign crossing = ({1'b0, boff_q} + size_bytes(sz_q)) > 3'd4;
  assign rshift   = 3'd4 - {1'b0, boff_q};
  assign ld_dword = crossing ? {sram_rdata, word0_q} : {32'h0, sram_rdata};
`else
  assign aligned  = !((req_sz == SZ_H) && req_adr[0]) &&
                    !((req_sz == SZ_W) && (req_adr[1:0] != 2'b00));
  assign ld_dword = {32'h0, sram_rdata};
`endif

  assign req_legal = ((req_acc_type == ACC_RD) || (req_acc_type == ACC_WR)) &&
                     (req_sz != 2'b11) && aligned;

  rv32i_ld_align u_ld_align (
    .dword (ld_dword),
    .boff  (boff_q),
    .sz    (sz_q),
    .s_us  (s_us_q),
    .data  (ld_data)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_adr   = '0;
    sram_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_legal ? ACC0 : RSP;
      end
      ACC0: begin
        sram_en    = 1'b1;
        sram_we    = is_wr_q;
        sram_be    = mask << boff_q;
        sram_adr   = a_q;
        sram_wdata = wdata_q << {boff_q, 3'b000};
`ifdef RV32I_DMEM_MISALIGN_EN
        state_nxt  = crossing ? ACC1 : CAP;
`else
        state_nxt  = CAP;
`endif
      end
`ifdef RV32I_DMEM_MISALIGN_EN
      ACC1: begin
        sram_en    = 1'b1;
        sram_we    = is_wr_q;
        sram_be    = mask >> rshift;
        sram_adr   = a_q + AW'(1);
        sram_wdata = wdata_q >> {rshift, 3'b000};
        state_nxt  = CAP;
      end
`endif
      CAP:     state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RSP);
  assign rsp_err   = (state == RSP) && err_q;
  assign rsp_rdata = (state == RSP) ? rdata_q : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      is_wr_q <= 1'b0;
      sz_q    <= SZ_B;
      boff_q  <= 2'b00;
      s_us_q  <= 1'b0;
      wdata_q <= 32'h0;
      a_q     <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
`ifdef RV32I_DMEM_MISALIGN_EN
      word0_q <= 32'h0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      if (accept) begin
        is_wr_q <= (req_acc_type == ACC_WR);
        sz_q    <= req_sz;
        boff_q  <= req_adr[1:0];
        s_us_q  <= req_s_us;
        wdata_q <= req_wdata;
        a_q     <= req_adr[AW+1:2];
        err_q   <= !req_legal;
        rdata_q <= 32'h0;
      end
`ifdef RV32I_DMEM_MISALIGN_EN
      if (state == ACC1) word0_q <= sram_rdata;
`endif
      if (state == CAP) rdata_q <= is_wr_q ? 32'h0 : ld_data;
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Directed self-checking bench for rv32i_dmem_ctrl with a behavioural 1-cycle SRAM.
// Expectations follow RV32I_DMEM_MISALIGN_EN in the same way as the design.
`timescale 1ns/1ps
module tb_rv32i_dmem_ctrl;
  import rv32i_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_acc_type = 2'b00;
  logic [31:0]   req_adr = 32'h0;
  logic [1:0]    req_sz = 2'b00;
  logic          req_s_us = 1'b0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          sram_en;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  always #5 clk = ~clk;

  rv32i_dmem_ctrl #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_acc_type (req_acc_type),
    .req_adr      (req_adr),
    .req_sz       (req_sz),
    .req_s_us     (req_s_us),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_be      (sram_be),
    .sram_adr     (sram_adr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] adr;
    logic [31:0]   wdata;
    int            cyc;
  } txn_t;

  logic [31:0] mem [0:(1<<AW)-1];
  txn_t        log_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // SRAM model: byte-masked writes, registered reads, plus an access log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_en) begin
      log_q.push_back('{sram_we, sram_be, sram_adr, sram_wdata, cyc});
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) mem[sram_adr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= mem[sram_adr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_txn(input string tag, input int idx, input logic we, input logic [3:0] be,
                           input logic [AW-1:0] adr, input logic [31:0] wd, input int off);
    if (idx >= log_q.size()) begin
      check({tag, " present"}, log_q.size(), idx + 1);
    end else begin
      check({tag, " we"},  log_q[idx].we,  we);
      check({tag, " be"},  log_q[idx].be,  be);
      check({tag, " adr"}, log_q[idx].adr, adr);
      check({tag, " cyc"}, log_q[idx].cyc - acc_cyc, off);
      if (we) check({tag, " wdata"}, log_q[idx].wdata, wd);
    end
  endtask

  // Issue one request, wait (bounded) for the response and compare it.
  task automatic run(input string tag, input logic [1:0] t, input logic [31:0] a, input logic [1:0] sz,
                     input logic su, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input int exp_lat, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_acc_type = t; req_adr = a; req_sz = sz; req_s_us = su; req_wdata = wd;
    log_q.delete();
    acc_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, rsp_err, exp_err);
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    if (exp_err) check({tag, " no sram"}, log_q.size(), 0);
    @(negedge clk);
    check({tag, " pulse"}, rsp_valid, 1'b0);
  endtask

  int seen;

  initial begin
    #1;
    check("reset rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
    check("reset sram", {sram_en, sram_we, sram_be, sram_adr, sram_wdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready after reset", req_ready, 1'b1);

    // Stores (also preload for the loads below).
    run("sw 0x10", ACC_WR, 32'h10, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 3, 1'b0);
    check("sw 0x10 count", log_q.size(), 1);
    check_txn("sw 0x10 t0", 0, 1'b1, 4'b1111, 8'd4, 32'hDEADBEEF, 1);
    run("sw 0x14", ACC_WR, 32'h14, SZ_W, 1'b0, 32'h11223344, 32'h0, 3, 1'b0);
    run("sw 0x3fc", ACC_WR, 32'h3FC, SZ_W, 1'b0, 32'hCAFEBABE, 32'h0, 3, 1'b0);
    run("sw 0x0", ACC_WR, 32'h0, SZ_W, 1'b0, 32'h01234567, 32'h0, 3, 1'b0);

    // Aligned and within-word loads.
    run("lb 0x13", ACC_RD, 32'h13, SZ_B, 1'b0, 32'h0, 32'hFFFFFFDE, 3, 1'b0);
    check_txn("lb 0x13 t0", 0, 1'b0, 4'b1000, 8'd4, 32'h0, 1);
    run("lbu 0x13", ACC_RD, 32'h13, SZ_B, 1'b1, 32'h0, 32'h000000DE, 3, 1'b0);
    run("lb 0x10", ACC_RD, 32'h10, SZ_B, 1'b0, 32'h0, 32'hFFFFFFEF, 3, 1'b0);
    run("lbu 0x14", ACC_RD, 32'h14, SZ_B, 1'b1, 32'h0, 32'h00000044, 3, 1'b0);
    run("lh 0x12", ACC_RD, 32'h12, SZ_H, 1'b0, 32'h0, 32'hFFFFDEAD, 3, 1'b0);
    run("lhu 0x12", ACC_RD, 32'h12, SZ_H, 1'b1, 32'h0, 32'h0000DEAD, 3, 1'b0);
    run("lw 0x14", ACC_RD, 32'h14, SZ_W, 1'b0, 32'h0, 32'h11223344, 3, 1'b0);

`ifdef RV32I_DMEM_MISALIGN_EN
    run("lh 0x11", ACC_RD, 32'h11, SZ_H, 1'b0, 32'h0, 32'hFFFFADBE, 3, 1'b0);
    run("lw 0x12", ACC_RD, 32'h12, SZ_W, 1'b0, 32'h0, 32'h3344DEAD, 4, 1'b0);
    check_txn("lw 0x12 t0", 0, 1'b0, 4'b1100, 8'd4, 32'h0, 1);
    check_txn("lw 0x12 t1", 1, 1'b0, 4'b0011, 8'd5, 32'h0, 2);
    run("lw 0x3fe", ACC_RD, 32'h3FE, SZ_W, 1'b0, 32'h0, 32'h4567CAFE, 4, 1'b0);
    check_txn("lw 0x3fe t0", 0, 1'b0, 4'b1100, 8'd255, 32'h0, 1);
    check_txn("lw 0x3fe t1", 1, 1'b0, 4'b0011, 8'd0, 32'h0, 2);
    run("sh 0x17", ACC_WR, 32'h17, SZ_H, 1'b0, 32'h0000A55A, 32'h0, 4, 1'b0);
    check("sh 0x17 count", log_q.size(), 2);
    check_txn("sh 0x17 t0", 0, 1'b1, 4'b1000, 8'd5, 32'h5A000000, 1);
    check_txn("sh 0x17 t1", 1, 1'b1, 4'b0001, 8'd6, 32'h000000A5, 2);
    run("lhu 0x17", ACC_RD, 32'h17, SZ_H, 1'b1, 32'h0, 32'h0000A55A, 4, 1'b0);
    run("lw 0x14 after sh", ACC_RD, 32'h14, SZ_W, 1'b0, 32'h0, 32'h5A223344, 3, 1'b0);
`else
    run("lh 0x11", ACC_RD, 32'h11, SZ_H, 1'b0, 32'h0, 32'h0, 1, 1'b1);
    run("lw 0x12", ACC_RD, 32'h12, SZ_W, 1'b0, 32'h0, 32'h0, 1, 1'b1);
    run("lw 0x3fe", ACC_RD, 32'h3FE, SZ_W, 1'b0, 32'h0, 32'h0, 1, 1'b1);
    run("sh 0x17", ACC_WR, 32'h17, SZ_H, 1'b0, 32'h0000A55A, 32'h0, 1, 1'b1);
    run("lw 0x14 after sh", ACC_RD, 32'h14, SZ_W, 1'b0, 32'h0, 32'h11223344, 3, 1'b0);
`endif

    // Illegal size / type.
    run("sz 11", ACC_RD, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1, 1'b1);
    run("type 00", 2'b00, 32'h10, SZ_W, 1'b0, 32'h0, 32'h0, 1, 1'b1);
    run("type 11 store", 2'b11, 32'h10, SZ_W, 1'b0, 32'h12345678, 32'h0, 1, 1'b1);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    req_valid = 1'b1; req_acc_type = ACC_RD; req_sz = SZ_W; req_s_us = 1'b0;
`ifdef RV32I_DMEM_MISALIGN_EN
    req_adr = 32'h12;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`else
    req_adr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
`endif
    @(negedge clk);
    check("mid access en", sram_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset en drop", {sram_en, sram_we, sram_be, sram_wdata}, 0);
    check("reset ready/rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready after mid reset", req_ready, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no rsp after reset", seen, 0);
    run("lw 0x10 after reset", ACC_RD, 32'h10, SZ_W, 1'b0, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    check_txn("lw 0x10 t0", 0, 1'b0, 4'b1111, 8'd4, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
